// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state/direction encodings and floor mask helpers for the N-floor elevator
package elevator_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE      = 2'd0;
  localparam state_t MOVE_UP   = 2'd1;
  localparam state_t MOVE_DOWN = 2'd2;
  localparam state_t DOOR_OPEN = 2'd3;
  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;
  localparam int MAX_FLOORS = 32;
  function automatic logic [MAX_FLOORS-1:0] above_mask(input int floor);
    return {MAX_FLOORS{1'b1}} << (floor + 1);
  endfunction
  function automatic logic [MAX_FLOORS-1:0] below_mask(input int floor);
    return (MAX_FLOORS'(1) << floor) - MAX_FLOORS'(1);
  endfunction
endpackage

// File: rtl/elevator_req_reg.sv
// elevator_req_reg: pending call latch with floor clear and above/below/here masks
module elevator_req_reg import elevator_pkg::*; #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W = NUM_FLOORS > 1 ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  clear_en,
  input  logic [FLOOR_W-1:0]    clear_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [NUM_FLOORS-1:0] above,
  output logic [NUM_FLOORS-1:0] below,
  output logic                  here
);
  logic [NUM_FLOORS-1:0] clear;
  assign clear = clear_en ? NUM_FLOORS'(1) << clear_floor : '0;
  assign above = pending & NUM_FLOORS'(above_mask(int'(cur_floor)));
  assign below = pending & NUM_FLOORS'(below_mask(int'(cur_floor)));
  assign here  = |(pending & (NUM_FLOORS'(1) << cur_floor));
  // latch new calls; the floor being served is cleared so its call never sticks
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pending <= '0;
    else pending <= (pending | call_req) & ~clear;
endmodule

// File: rtl/elevator_nfloor.sv
// elevator_nfloor: N-floor SCAN elevator controller with per-floor travel time and held door
module elevator_nfloor import elevator_pkg::*; #(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int FLOOR_W       = NUM_FLOORS > 1 ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  hold,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS-1:0] floor_onehot,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);
  localparam int TW = TRAVEL_CYCLES > 1 ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = DOOR_CYCLES > 1 ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LOAD = DW'(DOOR_CYCLES - 1);
  state_t state, nxt_state;
  logic last_dir, nxt_dir, exit_dir, ahead, behind, here, call_here, hit_up, hit_dn, clear_en;
  logic [FLOOR_W-1:0] nxt_floor, up_floor, dn_floor;
  logic [TW-1:0] travel_cnt, nxt_tc;
  logic [DW-1:0] door_cnt, nxt_dc;
  logic [NUM_FLOORS-1:0] above, below;
  elevator_req_reg #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_req (
    .clk(clk), .reset_n(reset_n), .call_req(call_req), .cur_floor(cur_floor),
    .clear_en(clear_en), .clear_floor(nxt_floor), .pending(pending),
    .above(above), .below(below), .here(here)
  );
  assign up_floor     = cur_floor + 1'b1;
  assign dn_floor     = cur_floor - 1'b1;
  assign hit_up       = |(pending & (NUM_FLOORS'(1) << up_floor));
  assign hit_dn       = |(pending & (NUM_FLOORS'(1) << dn_floor));
  assign floor_onehot = NUM_FLOORS'(1) << cur_floor;
  assign call_here    = |(call_req & floor_onehot);
  assign ahead        = last_dir == UP ? |above : |below;
  assign behind       = last_dir == UP ? |below : |above;
  assign exit_dir     = ahead ? last_dir : ~last_dir;
  assign clear_en     = state == DOOR_OPEN || nxt_state == DOOR_OPEN;
  assign moving_up    = state == MOVE_UP;
  assign moving_down  = state == MOVE_DOWN;
  assign door_open    = state == DOOR_OPEN;
  // SCAN policy: keep direction while calls lie ahead, reverse when only calls behind remain
  always_comb begin
    nxt_state = state;
    nxt_floor = cur_floor;
    nxt_dir   = last_dir;
    nxt_tc    = travel_cnt;
    nxt_dc    = door_cnt;
    case (state)
      IDLE: begin
        if (here) begin
          nxt_state = DOOR_OPEN;
          nxt_dc    = D_LOAD;
        end else if (|above && (last_dir == UP || !(|below))) begin
          nxt_state = MOVE_UP;
          nxt_tc    = T_LOAD;
        end else if (|below) begin
          nxt_state = MOVE_DOWN;
          nxt_tc    = T_LOAD;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (travel_cnt != '0) nxt_tc = travel_cnt - 1'b1;
        else begin
          nxt_floor = state == MOVE_UP ? up_floor : dn_floor;
          nxt_dir   = state == MOVE_UP ? UP : DOWN;
          nxt_state = (state == MOVE_UP ? hit_up : hit_dn) ? DOOR_OPEN : state;
          nxt_tc    = T_LOAD;
          nxt_dc    = D_LOAD;
        end
      end
      default: begin
        if (call_here) nxt_dc = D_LOAD;
        else if (!hold) begin
          if (door_cnt != '0) nxt_dc = door_cnt - 1'b1;
          else begin
            nxt_state = !(ahead || behind) ? IDLE : exit_dir == UP ? MOVE_UP : MOVE_DOWN;
            nxt_tc    = T_LOAD;
          end
        end
      end
    endcase
  end
  // state, floor, direction and timer registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      cur_floor  <= '0;
      last_dir   <= UP;
      travel_cnt <= '0;
      door_cnt   <= '0;
    end else begin
      state      <= nxt_state;
      cur_floor  <= nxt_floor;
      last_dir   <= nxt_dir;
      travel_cnt <= nxt_tc;
      door_cnt   <= nxt_dc;
    end
endmodule

// File: doc/elevator_nfloor.md
Name: elevator_nfloor

Overview:
Parametrised N-floor elevator controller, the multi-floor successor to the 2-floor controller. Latches hall/car calls in a pending-request register and serves them with a collective (SCAN) policy: it keeps its direction while requests lie ahead, then reverses. Models per-floor travel time, a timed door with hold, and exposes current floor, direction and pending calls to the top level.

Parameters:
NUM_FLOORS, 4, number of floors (>=2); floor 0 is the bottom floor
TRAVEL_CYCLES, 8, clk cycles to travel one floor (>=1)
DOOR_CYCLES, 4, clk cycles the door stays open, excluding hold cycles (>=1)
FLOOR_W, $clog2(NUM_FLOORS), width of the floor index (derived; minimum 1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
call_req  in  NUM_FLOORS  one bit per floor; a pulse or level of any length registers a call
hold  in  1  holds the door open while high in DOOR_OPEN; ignored in other states
cur_floor  out  FLOOR_W  current floor index
floor_onehot  out  NUM_FLOORS  one-hot decode of cur_floor
moving_up  out  1  high in MOVE_UP
moving_down  out  1  high in MOVE_DOWN
door_open  out  1  high in DOOR_OPEN
pending  out  NUM_FLOORS  latched, not-yet-served calls

Behaviour:
- Reset (async, reset_n low): state IDLE, cur_floor 0, floor_onehot 1, pending 0, last_dir UP, timers 0, all other outputs 0. Asserting reset mid-travel or mid-door drops everything to these values at once, with no completion of the move.
- All outputs are registered or decoded from registered state. No combinational path runs from an input to an output.
- Request latch, every edge: pending <= (pending | call_req) & ~clear. clear is the one-hot of cur_floor on the edge that enters DOOR_OPEN, and on every DOOR_OPEN edge.
- A call for the current floor during DOOR_OPEN never sets pending and reloads the door timer to DOOR_CYCLES-1.
- Masks: above = pending bits > cur_floor; below = pending bits < cur_floor; here = pending[cur_floor].
- IDLE:
  - here -> DOOR_OPEN.
  - else above and (last_dir==UP or no below) -> MOVE_UP.
  - else below -> MOVE_DOWN.
  - else stay in IDLE.
  - Decisions use pending as registered, so a call is acted on one edge after it is latched.
- MOVE_UP/MOVE_DOWN:
  - On entry, travel counter <= TRAVEL_CYCLES-1; it decrements each edge.
  - On the edge where it is 0, cur_floor moves by +/-1 and last_dir is recorded.
  - If pending[new floor] -> DOOR_OPEN; otherwise reload the counter and continue.
  - Each floor costs exactly TRAVEL_CYCLES cycles in the move state.
- DOOR_OPEN:
  - On entry, door timer <= DOOR_CYCLES-1.
  - It decrements each edge with hold low and freezes with hold high.
  - On the edge where it is 0 with hold low:
    - requests ahead in last_dir -> continue that direction;
    - else requests the other way -> reverse;
    - else -> IDLE.
- Boundaries:
  - cur_floor never goes below 0 or above NUM_FLOORS-1. By construction, a move starts only toward a pending floor.
  - At floor NUM_FLOORS-1, last_dir UP with only below pending -> reverse.
- Simultaneous calls on several floors are all latched in one edge. Stops occur in floor order along the current direction.
- moving_up, moving_down and door_open are mutually exclusive.

Decomposition:
- elevator_pkg: state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN), direction enum (UP, DOWN), function to build the above/below masks for a given floor.
- Sub-module elevator_req_reg: holds the pending latch, the clear logic and the above/below/here mask generation. The top level holds the FSM, the timers and the floor counter.

Test Plan:
- Defaults, idle at floor 0, 1-cycle call_req[2] -> moving_up for 16 cycles, cur_floor 0->1->2, door_open 4 cycles, then IDLE with pending 0.
- At floor 0, call_req=4'b1010 in one cycle -> stops at 1 (door 4 cycles), continues up, stops at 3; pending goes 1010->1000->0000.
- At floor 1 moving up toward 3, call_req[0] pulsed -> serves 3 first, then moving_down through 2 and 1 to 0; last_dir ends DOWN.
- In DOOR_OPEN at floor 2, hold high for 10 cycles mid-timer -> door_open high for 14 cycles total; cur_floor stays 2.
- IDLE at floor 1, call_req[1] -> door_open on the second edge with no movement; call_req[1] again while open -> timer reloaded, door_open extends, pending[1] stays 0.
- reset_n driven low during MOVE_UP between floors 1 and 2 -> outputs go to reset values immediately (cur_floor 0, pending 0); after release, state IDLE.
